ad9228_serial_tx_emulator: RTL and testbench

Single-lane transmitter for the AD9228 serial LVDS output format: serializes DATA_WIDTH-bit samples MSB-first, one bit per clk, with a frame clock (FCO) that is high for the first half of each frame. Drives the ADC capture path in loopback/self-test builds and in simulation benches, so the deserializer and FIFO path can be exercised without a physical ADC. Sources are a streamed sample interface or built-in test patterns (fixed, ramp, checkerboard, midscale).

---
 rtl/ad9228_serial_tx_emulator.sv | 107 ++++++++++
 tb/tb_ad9228_serial_tx_emulator.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ad9228_serial_tx_emulator.sv
// AD9228-style single-lane serializer: one frame of DATA_WIDTH bits MSB-first, FCO high for the leading bits.
// Latency 1 cycle from enable to the first MSB; stream samples are taken only at frame boundaries, and a missing sample repeats the last word.
module ad9228_serial_tx_emulator #(
  parameter int DATA_WIDTH    = 12,
  parameter bit DOUT_INVERTED = 1'b0,
  parameter int FCO_HIGH_BITS = DATA_WIDTH / 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic [2:0]            mode,
  input  logic [DATA_WIDTH-1:0] fixed_word,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  dout,
  output logic                  fco,
  output logic                  frame_start,
  output logic [31:0]           frames_sent,
  output logic                  underrun,
  input  logic                  underrun_clr
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] CHECKER  = {(DATA_WIDTH/2){2'b10}};
  localparam logic [DATA_WIDTH-1:0] MIDSCALE = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] ramp_cnt;
  logic [DATA_WIDTH-1:0] last_word;
  logic                  chk_phase;
  logic [DATA_WIDTH-1:0] word;
  logic                  load;
  logic                  stream_miss;

  // A new frame can only begin from IDLE or on the last bit of the current one.
  assign load        = enable && ((state == IDLE) || (bit_cnt == LAST_BIT));
  assign s_ready     = load && (mode == 3'd0) && s_valid;
  assign stream_miss = load && (mode == 3'd0) && !s_valid;

  always_comb begin
    word = fixed_word;
    case (mode)
      3'd0:    word = s_valid ? s_data : last_word;
      3'd2:    word = ramp_cnt;
      3'd3:    word = chk_phase ? ~CHECKER : CHECKER;
      3'd4:    word = MIDSCALE;
      default: word = fixed_word;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      ramp_cnt    <= '0;
      last_word   <= '0;
      chk_phase   <= 1'b0;
      dout        <= DOUT_INVERTED;
      fco         <= 1'b0;
      frame_start <= 1'b0;
      frames_sent <= '0;
      underrun    <= 1'b0;
    end else begin
      if (stream_miss)
        underrun <= 1'b1;
      else if (underrun_clr)
        underrun <= 1'b0;

      if (load) begin
        state       <= RUN;
        bit_cnt     <= '0;
        dout        <= word[DATA_WIDTH-1] ^ DOUT_INVERTED;
        shift_reg   <= word << 1;
        fco         <= (FCO_HIGH_BITS > 0);
        frame_start <= 1'b1;
        frames_sent <= frames_sent + 32'd1;
        last_word   <= word;
        if (mode == 3'd2)
          ramp_cnt <= ramp_cnt + 1'b1;
        if (mode == 3'd3)
          chk_phase <= ~chk_phase;
      end else if (state == RUN) begin
        frame_start <= 1'b0;
        if (bit_cnt != LAST_BIT) begin
          dout      <= shift_reg[DATA_WIDTH-1] ^ DOUT_INVERTED;
          shift_reg <= shift_reg << 1;
          bit_cnt   <= bit_cnt + 1'b1;
          fco       <= (int'(bit_cnt) + 1) < FCO_HIGH_BITS;
        end else begin
          // enable dropped: the frame has finished, park the line
          state   <= IDLE;
          bit_cnt <= '0;
          dout    <= DOUT_INVERTED;
          fco     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ad9228_serial_tx_emulator.sv
// Bench for ad9228_serial_tx_emulator: frame-level reference model, directed scenarios plus random frames.
module tb_ad9228_serial_tx_emulator;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rstn, enable, s_valid, underrun_clr;
  logic [2:0]   mode;
  logic [W-1:0] fixed_word, s_data;
  logic         s_ready, dout, fco, frame_start, underrun;
  logic [31:0]  frames_sent;

  logic         inv_enable;
  logic         inv_s_ready, inv_dout, inv_fco, inv_frame_start, inv_underrun;
  logic [31:0]  inv_frames_sent;

  always #5 clk = ~clk;

  ad9228_serial_tx_emulator #(.DATA_WIDTH(W), .DOUT_INVERTED(1'b0)) u_dut (
    .clk(clk), .rstn(rstn), .enable(enable), .mode(mode), .fixed_word(fixed_word),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .dout(dout), .fco(fco),
    .frame_start(frame_start), .frames_sent(frames_sent), .underrun(underrun),
    .underrun_clr(underrun_clr)
  );

  ad9228_serial_tx_emulator #(.DATA_WIDTH(W), .DOUT_INVERTED(1'b1)) u_inv (
    .clk(clk), .rstn(rstn), .enable(inv_enable), .mode(3'd1), .fixed_word(12'hFFF),
    .s_data(12'h000), .s_valid(1'b0), .s_ready(inv_s_ready), .dout(inv_dout), .fco(inv_fco),
    .frame_start(inv_frame_start), .frames_sent(inv_frames_sent), .underrun(inv_underrun),
    .underrun_clr(1'b0)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state, kept at frame granularity.
  logic [W-1:0] m_ramp, m_last;
  bit           m_phase, m_ur;
  logic [31:0]  m_frames;

  task automatic model_reset();
    m_ramp = '0; m_last = '0; m_phase = 1'b0; m_ur = 1'b0; m_frames = '0;
  endtask

  function automatic logic [W-1:0] checker_word();
    logic [W-1:0] w;
    for (int i = 0; i < W; i++) w[i] = (i % 2 == 1);
    return w;
  endfunction

  // Entered between edges with the next edge being a load edge; returns W edges later.
  task automatic send_frame(input logic [2:0] m, input logic sv, input logic [W-1:0] sd,
                            input logic [W-1:0] fw, input logic clr, input int drop_at,
                            input int sw_mode, output logic [W-1:0] got);
    logic [W-1:0] exp_w;
    bit miss;
    enable = 1'b1; mode = m; s_valid = sv; s_data = sd; fixed_word = fw; underrun_clr = clr;
    #1;
    chk("s_ready_load", 32'(s_ready), 32'(m == 3'd0 && sv));
    miss = 1'b0;
    case (m)
      3'd0: if (sv) exp_w = sd; else begin exp_w = m_last; miss = 1'b1; end
      3'd2: begin exp_w = m_ramp; m_ramp = m_ramp + 1'b1; end
      3'd3: begin exp_w = m_phase ? ~checker_word() : checker_word(); m_phase = ~m_phase; end
      3'd4: exp_w = W'(1) << (W - 1);
      default: exp_w = fw;
    endcase
    m_last = exp_w;
    m_frames++;
    if (miss) m_ur = 1'b1;
    else if (clr) m_ur = 1'b0;
    got = '0;
    for (int k = 0; k < W; k++) begin
      @(posedge clk); #1;
      chk("dout", 32'(dout), 32'(exp_w[W-1-k]));
      chk("fco", 32'(fco), 32'(k < W/2));
      chk("frame_start", 32'(frame_start), 32'(k == 0));
      got = {got[W-2:0], dout};
      underrun_clr = 1'b0;
      if (k < W-1) begin
        if (sw_mode >= 0 && k >= 5) mode = sw_mode[2:0];
        else mode = 3'($urandom_range(0, 7));
        s_valid = 1'($urandom);
        s_data = W'($urandom);
        fixed_word = W'($urandom);
        if (k == drop_at) enable = 1'b0;
        #1;
        chk("s_ready_mid", 32'(s_ready), 32'd0);
      end
    end
    chk("frames_sent", frames_sent, m_frames);
    chk("underrun", 32'(underrun), 32'(m_ur));
  endtask

  task automatic idle_check(input int n);
    enable = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("idle_dout", 32'(dout), 32'd0);
      chk("idle_fco", 32'(fco), 32'd0);
      chk("idle_fs", 32'(frame_start), 32'd0);
      chk("idle_frames", frames_sent, m_frames);
      mode = 3'd0; s_valid = 1'b1;
      #1;
      chk("idle_s_ready", 32'(s_ready), 32'd0);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_fco", 32'(fco), 32'd0);
    chk("rst_fs", 32'(frame_start), 32'd0);
    chk("rst_frames", frames_sent, 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_inv_dout", 32'(inv_dout), 32'd1);
    model_reset();
    enable = 1'b0;
    rstn = 1'b1;
    #1;
  endtask

  logic [W-1:0] got;

  initial begin
    rstn = 1'b0; enable = 1'b0; mode = 3'd0; s_valid = 1'b0; s_data = '0;
    fixed_word = '0; underrun_clr = 1'b0; inv_enable = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Inverted output: fixed all-ones sends all zeros, idles high; fco unaffected.
    @(posedge clk); #1;
    chk("inv_idle_dout", 32'(inv_dout), 32'd1);
    inv_enable = 1'b1;
    for (int k = 0; k < 2*W; k++) begin
      @(posedge clk); #1;
      chk("inv_dout", 32'(inv_dout), 32'd0);
      chk("inv_fco", 32'(inv_fco), 32'((k % W) < W/2));
      chk("inv_fs", 32'(inv_frame_start), 32'((k % W) == 0));
      if (k == W + 3) inv_enable = 1'b0;
    end
    @(posedge clk); #1;
    chk("inv_end_dout", 32'(inv_dout), 32'd1);
    chk("inv_end_fco", 32'(inv_fco), 32'd0);
    chk("inv_frames", inv_frames_sent, 32'd2);

    // Fixed word, five back-to-back frames.
    for (int i = 0; i < 5; i++) begin
      send_frame(3'd1, 1'b0, '0, 12'hA5C, 1'b0, -1, -1, got);
      chk("fixed_word", 32'(got), 32'hA5C);
    end
    chk("fixed_frames5", frames_sent, 32'd5);
    do_reset();

    // Ramp across the wrap.
    for (int i = 0; i < 4100; i++) begin
      send_frame(3'd2, 1'b0, '0, '0, 1'b0, -1, -1, got);
      chk("ramp_word", 32'(got), 32'(i % 4096));
    end
    chk("ramp_frames", frames_sent, 32'd4100);
    do_reset();

    // Stream with one missing sample, sticky underrun, clear, and set-beats-clear.
    send_frame(3'd0, 1'b1, 12'h123, '0, 1'b0, -1, -1, got);
    chk("stream_w0", 32'(got), 32'h123);
    send_frame(3'd0, 1'b1, 12'h456, '0, 1'b0, -1, -1, got);
    chk("stream_w1", 32'(got), 32'h456);
    chk("stream_no_ur", 32'(underrun), 32'd0);
    send_frame(3'd0, 1'b0, 12'h789, '0, 1'b0, -1, -1, got);
    chk("stream_repeat", 32'(got), 32'h456);
    chk("stream_ur_set", 32'(underrun), 32'd1);
    send_frame(3'd1, 1'b0, '0, 12'h0F0, 1'b0, -1, -1, got);
    chk("stream_ur_sticky", 32'(underrun), 32'd1);
    send_frame(3'd1, 1'b0, '0, 12'h0F0, 1'b1, -1, -1, got);
    chk("stream_ur_clr", 32'(underrun), 32'd0);
    send_frame(3'd0, 1'b0, '0, '0, 1'b1, -1, -1, got);
    chk("stream_set_wins", 32'(underrun), 32'd1);
    chk("stream_last_rep", 32'(got), 32'h0F0);

    // Checkerboard, mode changed mid-frame to midscale, then back.
    send_frame(3'd3, 1'b0, '0, '0, 1'b0, -1, 4, got);
    chk("checker_a", 32'(got), 32'hAAA);
    send_frame(3'd4, 1'b0, '0, '0, 1'b0, -1, 3, got);
    chk("midscale", 32'(got), 32'h800);
    send_frame(3'd3, 1'b0, '0, '0, 1'b0, -1, -1, got);
    chk("checker_5", 32'(got), 32'h555);

    // enable dropped at bit 3: frame completes, then idle.
    send_frame(3'd1, 1'b0, '0, 12'h3C3, 1'b0, 3, -1, got);
    chk("drop_word", 32'(got), 32'h3C3);
    idle_check(3);

    // Reset asserted at bit 7 of a frame.
    enable = 1'b1; mode = 3'd1; fixed_word = 12'hFFF;
    repeat (8) @(posedge clk);
    #1;
    chk("pre_rst_dout", 32'(dout), 32'd1);
    chk("pre_rst_frames", frames_sent, m_frames + 32'd1);
    do_reset();
    idle_check(2);

    // Random frames against the model.
    for (int i = 0; i < 300; i++) begin
      int drop;
      drop = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, W-2)) : -1;
      send_frame(3'($urandom_range(0, 7)), 1'($urandom), W'($urandom), W'($urandom),
                 ($urandom_range(0, 3) == 0), drop, -1, got);
      if (drop >= 0) idle_check(int'($urandom_range(1, 3)));
      if ($urandom_range(0, 49) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
